regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the single 128x8 motor-controller register-file port between N_REQ requesters.
//  Requester 0 is the SPI slave: fixed top priority, never stalled. Requesters 1..N_REQ-1
//  (motor sequencer, fault/IRQ logic, etc.) are served round-robin. A lock lets a requester
//  make multi-byte accesses (24-bit position, flags+position) without interleaving.
// PARAMETERS
//  N_REQ      3   number of requesters, 2..8; index 0 = priority requester
//  ADDR_W     7   register address width (128 entries)
//  DATA_W     8   register data width
//  STARVE_MAX 64  wait cycles before a round-robin requester's starve flag sets
// PORTS
//  clk          in   1               clock
//  reset        in   1               synchronous, active-high
//  req_valid    in   N_REQ           per-requester access request, held until granted
//  req_write    in   N_REQ           1 = write, 0 = read
//  req_lock     in   N_REQ           keep ownership after this access (RR requesters only)
//  req_addr     in   N_REQ*ADDR_W    packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_REQ*DATA_W    packed write data
//  req_grant    out  N_REQ           one-hot; access accepted this cycle
//  rsp_valid    out  N_REQ           one-hot; read data valid for that requester
//  rsp_rdata    out  DATA_W          read data (shared bus, qualified by rsp_valid)
//  ram_we       out  1               register-file write enable
//  ram_addr     out  ADDR_W          register-file address
//  ram_wdata    out  DATA_W          register-file write data
//  ram_rdata    in   DATA_W          register-file read data, 1-cycle synchronous latency
//  starve       out  N_REQ           sticky per-requester starvation flag (bit 0 always 0)
//  starve_clr   in   1               clears all starve bits and wait counters
// BEHAVIOUR
//  - Grant combinational from req_valid/state; RAM port driven in grant cycle T from winner.
//  - Read granted at T: rsp_valid[i]=1 and rsp_rdata=ram_rdata at T+1, exactly one cycle.
//  - Write granted at T: ram_we=1 at T; no response. No grant -> ram_we=0, ram_addr holds.
//  - Priority: req_valid[0] always wins, also while another requester holds the lock.
//  - FSM IDLE: winner = first requesting index after rr_ptr (wrapping 1..N_REQ-1, 0 skipped);
//    after grant rr_ptr <= winner. Grant with req_lock=1 -> LOCKED(owner=winner).
//  - FSM LOCKED: only owner (or req 0) granted; owner grant with req_lock=0 -> IDLE.
//    Owner may idle while LOCKED; lock has no timeout, starve counters still run.
//  - Preemption by req 0 in LOCKED: req 0 served, owner and lock kept, rr_ptr unchanged.
//  - Simultaneous req 0 + owner in same cycle: req 0 granted, owner waits (req_valid held).
//  - req_lock on requester 0 ignored.
//  - Starvation: per RR requester, wait counter (clog2(STARVE_MAX+1) bits, saturating)
//    increments each cycle req_valid=1 and not granted; cleared on grant; starve[i] sets
//    when counter reaches STARVE_MAX, held until starve_clr or reset. starve_clr wins over set.
//  - Reset (also mid-lock or mid-read): state IDLE, rr_ptr=N_REQ-1 (first RR pick = 1),
//    req_grant=0, rsp_valid=0, rsp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, starve=0,
//    counters=0; read granted in reset-asserted cycle gets no rsp_valid.
//  - Grant never issued during reset. Read-after-write to same address by different
//    requesters in consecutive cycles returns new data (RAM write-first not required:
//    write at T, read at T+1 sees it).
// STRUCTURE
//  - Shared package: ADDR_W/DATA_W defaults, register map constants (per-channel flags/
//    position at ch*4, speed/target at 64+ch*4), requester index constants (REQ_SPI=0,
//    REQ_MC=1, REQ_IRQ=2).
//  - One sub-module: rr_pick (mask-and-priority-encode round-robin pick over N_REQ-1 bits).
//  - FSM, rsp pipeline register and starve counters stay in this module.
// TESTING
//  - RR fairness: req 1,2 both held 10 cycles -> grants alternate 1,2,1,2...; first is 1.
//  - SPI priority: req0 read addr 0x05 same cycle as req1 -> grant[0], rsp_valid[0] at T+1
//    with RAM[0x05]; req1 granted T+1.
//  - Lock: req1 reads 0x01..0x03 with lock=1,1,0 while req2 requests -> req2 granted only
//    after third access; req0 write 0x40=0x7F mid-sequence preempts, lock retained.
//  - Starvation: req0 held continuously 70 cycles with req1 pending, STARVE_MAX=64 ->
//    starve[1]=1 at wait cycle 64; starve_clr -> 0.
//  - RAW: req1 writes 0x10=0xA5 at T, req2 reads 0x10 at T+1 -> rsp_rdata=0xA5 at T+2.
//  - Reset mid-LOCKED with read in flight -> no rsp_valid, state IDLE, next pick req1.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared constants for the register-file port arbiter
//
// Purpose: default register-file geometry, motor-controller register map helpers,
//          requester index assignments and the arbiter state type.
// Ports:   none (package).
package regfile_port_arbiter_pkg;

  localparam int RF_ADDR_W = 7;
  localparam int RF_DATA_W = 8;

  // Requester indices; index 0 is the fixed-priority SPI slave.
  localparam int REQ_SPI = 0;
  localparam int REQ_MC  = 1;
  localparam int REQ_IRQ = 2;

  // Register map: each channel owns a 4-byte slot in the low half (flags then
  // 24-bit position) and another in the upper half (speed then target).
  localparam int REG_CH_STRIDE  = 4;
  localparam int REG_FLAGS_OFS  = 0;
  localparam int REG_POS_OFS    = 1;
  localparam int REG_SPEED_BASE = 64;
  localparam int REG_SPEED_OFS  = 0;
  localparam int REG_TARGET_OFS = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [RF_ADDR_W-1:0] ch_flags_addr(input int ch);
    return RF_ADDR_W'(ch * REG_CH_STRIDE + REG_FLAGS_OFS);
  endfunction

  function automatic logic [RF_ADDR_W-1:0] ch_pos_addr(input int ch);
    return RF_ADDR_W'(ch * REG_CH_STRIDE + REG_POS_OFS);
  endfunction

  function automatic logic [RF_ADDR_W-1:0] ch_speed_addr(input int ch);
    return RF_ADDR_W'(REG_SPEED_BASE + ch * REG_CH_STRIDE + REG_SPEED_OFS);
  endfunction

  function automatic logic [RF_ADDR_W-1:0] ch_target_addr(input int ch);
    return RF_ADDR_W'(REG_SPEED_BASE + ch * REG_CH_STRIDE + REG_TARGET_OFS);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// rtl/regfile_port_arbiter_rr_pick.sv - round-robin pick over the non-priority requesters
//
// Purpose: picks the first requesting bit strictly above ptr, wrapping to the
//          lowest requesting bit when nothing above ptr is requesting.
// Ports:
//   req   in  N   request bits (bit j = round-robin requester j)
//   ptr   in  IW  index of the most recently served requester
//   any   out 1   at least one request present
//   pick  out IW  chosen index (valid when any=1)
module regfile_port_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] pick
);

  logic [N-1:0] above;
  logic [N-1:0] masked;

  function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (v[j]) r = IW'(j);
    end
    return r;
  endfunction

  always_comb begin
    above = '0;
    for (int j = 0; j < N; j++) begin
      above[j] = (j > int'(ptr));
    end
  end

  assign masked = req & above;
  assign any    = |req;

  always_comb begin
    pick = '0;
    if (|masked) pick = lowest(masked);
    else         pick = lowest(req);
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares one register-file port between N_REQ requesters
//
// Purpose: requester 0 (SPI) has fixed top priority; requesters 1..N_REQ-1 are
//          served round-robin, with a lock for uninterrupted multi-byte accesses
//          and sticky per-requester starvation flags.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/write/lock   per-requester request, direction, keep-ownership
//   req_addr/req_wdata     packed per-requester address and write data
//   req_grant              one-hot, access accepted this cycle
//   rsp_valid/rsp_rdata    one-hot read-response strobe and shared read data
//   ram_we/addr/wdata      register-file port (driven in the grant cycle)
//   ram_rdata              register-file read data, one cycle after the address
//   starve/starve_clr      sticky starvation flags and their clear
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int STARVE_MAX = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [N_REQ-1:0]      req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]      req_grant,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [N_REQ-1:0]      starve,
  input  logic                  starve_clr
);

  localparam int IW  = $clog2(N_REQ);
  localparam int NRR = N_REQ - 1;
  localparam int CW  = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] rr_ptr_idx;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] rr_win;
  logic          rr_any;
  logic [IW-1:0] win;
  logic          win_en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [N_REQ-1:0]  rsp_q;
  logic [NRR-1:0]    starve_rr;

  // rr_pick works in 0-based round-robin space; requester k maps to bit k-1.
  assign rr_ptr_idx = rr_ptr - IW'(1);
  assign rr_win     = rr_idx + IW'(1);

  regfile_port_arbiter_rr_pick #(
    .N  (NRR),
    .IW (IW)
  ) u_rr_pick (
    .req  (req_valid[N_REQ-1:1]),
    .ptr  (rr_ptr_idx),
    .any  (rr_any),
    .pick (rr_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= IW'(N_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      rsp_q   <= req_grant & ~req_write;
    end
  end

  // SPI preempts everything without disturbing lock owner or rr_ptr.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    req_grant  = '0;
    win        = '0;
    win_en     = 1'b0;
    if (!reset) begin
      if (req_valid[REQ_SPI]) begin
        win    = IW'(REQ_SPI);
        win_en = 1'b1;
      end else if (state == ST_IDLE) begin
        if (rr_any) begin
          win        = rr_win;
          win_en     = 1'b1;
          rr_ptr_nxt = rr_win;
          if (req_lock[rr_win]) begin
            state_nxt = ST_LOCKED;
            owner_nxt = rr_win;
          end
        end
      end else begin
        if (req_valid[owner]) begin
          win    = owner;
          win_en = 1'b1;
          if (!req_lock[owner]) state_nxt = ST_IDLE;
        end
      end
      if (win_en) req_grant[win] = 1'b1;
    end
  end

  // Address and write data hold their last value when nobody is granted.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (win_en) begin
      ram_we    = req_write[win];
      ram_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
      ram_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  // A reset cycle swallows any read response already in flight.
  assign rsp_valid = reset ? '0 : rsp_q;
  assign rsp_rdata = (|rsp_valid) ? ram_rdata : '0;

  assign starve = {starve_rr, 1'b0};

  for (genvar gi = 1; gi < N_REQ; gi++) begin : g_starve
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          flag;

    always_comb begin
      cnt_nxt = cnt;
      if (req_grant[gi])                          cnt_nxt = '0;
      else if (req_valid[gi] && cnt != CNT_MAX)   cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset || starve_clr) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (cnt_nxt == CNT_MAX) flag <= 1'b1;
      end
    end

    assign starve_rr[gi-1] = flag;
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed bench for the register-file port arbiter
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid, req_write, req_lock;
  logic [20:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_grant, rsp_valid, starve;
  logic [7:0]  rsp_rdata, ram_wdata, ram_rdata;
  logic [6:0]  ram_addr;
  logic        ram_we, starve_clr;

  logic [7:0]  mem [128];
  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(
    .N_REQ(3), .ADDR_W(7), .DATA_W(8), .STARVE_MAX(64)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .starve(starve), .starve_clr(starve_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, one cycle latency, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rq(input int i, input logic v, input logic w, input logic l,
                    input logic [6:0] a, input logic [7:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_lock[i]  = l;
    req_addr[i*7 +: 7]  = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; starve_clr = 1'b0;
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

    // Reset state; a request during reset must not be granted.
    rq(REQ_MC, 1, 0, 0, 7'h33, 8'h00);
    cyc(); cyc(); settle();
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_starve", 32'(starve), 0);
    cyc();
    reset = 1'b0;

    // Round-robin fairness: 1,2,1,2,... starting with 1.
    rq(REQ_MC, 1, 0, 0, 7'h20, 8'h00);
    rq(REQ_IRQ, 1, 0, 0, 7'h21, 8'h00);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("rr_grant", 32'(req_grant), (k % 2 == 0) ? 2 : 4);
      if (k == 1) begin
        chk("rr_rsp1_valid", 32'(rsp_valid), 2);
        chk("rr_rsp1_data", 32'(rsp_rdata), 'h7A);
      end
      if (k == 2) begin
        chk("rr_rsp2_valid", 32'(rsp_valid), 4);
        chk("rr_rsp2_data", 32'(rsp_rdata), 'h7B);
      end
      cyc();
    end
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    rq(REQ_IRQ, 0, 0, 0, 7'h00, 8'h00);

    // SPI priority over a simultaneous round-robin request.
    rq(REQ_SPI, 1, 0, 0, 7'h05, 8'h00);
    rq(REQ_MC, 1, 0, 0, 7'h06, 8'h00);
    settle();
    chk("spi_grant", 32'(req_grant), 1);
    chk("spi_ram_addr", 32'(ram_addr), 'h05);
    chk("spi_ram_we", 32'(ram_we), 0);
    cyc();
    rq(REQ_SPI, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("spi_rsp_valid", 32'(rsp_valid), 1);
    chk("spi_rsp_data", 32'(rsp_rdata), 'h5F);
    chk("spi_then_req1", 32'(req_grant), 2);
    cyc();
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("req1_rsp_valid", 32'(rsp_valid), 2);
    chk("req1_rsp_data", 32'(rsp_rdata), 'h5C);
    cyc();

    // Locked 3-byte read by req1, req2 waiting, SPI write preempts mid-lock.
    rq(REQ_MC, 1, 0, 1, 7'h01, 8'h00);
    settle();
    chk("lk_first", 32'(req_grant), 2);
    cyc();
    rq(REQ_MC, 1, 0, 1, 7'h02, 8'h00);
    rq(REQ_IRQ, 1, 0, 0, 7'h40, 8'h00);
    rq(REQ_SPI, 1, 1, 0, 7'h40, 8'h7F);
    settle();
    chk("lk_preempt_grant", 32'(req_grant), 1);
    chk("lk_preempt_we", 32'(ram_we), 1);
    chk("lk_preempt_addr", 32'(ram_addr), 'h40);
    chk("lk_preempt_wdata", 32'(ram_wdata), 'h7F);
    chk("lk_rsp1_data", 32'(rsp_rdata), 'h5B);
    cyc();
    rq(REQ_SPI, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("lk_resume", 32'(req_grant), 2);
    chk("lk_resume_addr", 32'(ram_addr), 'h02);
    cyc();
    rq(REQ_MC, 1, 0, 0, 7'h03, 8'h00);
    settle();
    chk("lk_third", 32'(req_grant), 2);
    chk("lk_rsp2_data", 32'(rsp_rdata), 'h58);
    cyc();
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("lk_release", 32'(req_grant), 4);
    chk("lk_rsp3_valid", 32'(rsp_valid), 2);
    chk("lk_rsp3_data", 32'(rsp_rdata), 'h59);
    cyc();
    rq(REQ_IRQ, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("lk_spi_wr_seen_valid", 32'(rsp_valid), 4);
    chk("lk_spi_wr_seen_data", 32'(rsp_rdata), 'h7F);
    cyc();

    // Read-after-write across requesters.
    rq(REQ_MC, 1, 1, 0, 7'h10, 8'hA5);
    settle();
    chk("raw_wr_grant", 32'(req_grant), 2);
    chk("raw_wr_we", 32'(ram_we), 1);
    cyc();
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    rq(REQ_IRQ, 1, 0, 0, 7'h10, 8'h00);
    settle();
    chk("raw_rd_grant", 32'(req_grant), 4);
    cyc();
    rq(REQ_IRQ, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("raw_rsp_valid", 32'(rsp_valid), 4);
    chk("raw_rsp_data", 32'(rsp_rdata), 'hA5);
    chk("idle_we", 32'(ram_we), 0);
    chk("idle_addr_hold", 32'(ram_addr), 'h10);
    cyc();

    // Starvation: SPI hogs the port for 70 cycles while req1 waits.
    rq(REQ_SPI, 1, 0, 0, 7'h00, 8'h00);
    rq(REQ_MC, 1, 0, 0, 7'h11, 8'h00);
    for (int k = 1; k <= 70; k++) begin
      settle();
      if (k == 1)  chk("stv_spi_grant", 32'(req_grant), 1);
      if (k == 64) chk("stv_before", 32'(starve), 0);
      if (k == 65) chk("stv_set", 32'(starve), 2);
      if (k == 70) chk("stv_held", 32'(starve), 2);
      cyc();
    end
    rq(REQ_SPI, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("stv_req1_grant", 32'(req_grant), 2);
    chk("stv_sticky", 32'(starve), 2);
    cyc();
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    starve_clr = 1'b1;
    settle();
    chk("stv_clr_pending", 32'(starve), 2);
    cyc();
    starve_clr = 1'b0;
    settle();
    chk("stv_cleared", 32'(starve), 0);
    cyc();

    // Reset while LOCKED with a read in flight.
    rq(REQ_MC, 1, 0, 1, 7'h02, 8'h00);
    settle();
    chk("rl_grant", 32'(req_grant), 2);
    cyc();
    reset = 1'b1;
    rq(REQ_IRQ, 1, 0, 0, 7'h05, 8'h00);
    settle();
    chk("rl_rsp_dropped", 32'(rsp_valid), 0);
    chk("rl_no_grant", 32'(req_grant), 0);
    cyc();
    reset = 1'b0;
    rq(REQ_MC, 0, 0, 0, 7'h00, 8'h00);
    settle();
    chk("rl_unlocked", 32'(req_grant), 4);
    chk("rl_no_late_rsp", 32'(rsp_valid), 0);
    cyc();

    // req_lock on the SPI requester has no effect.
    rq(REQ_IRQ, 0, 0, 0, 7'h00, 8'h00);
    rq(REQ_SPI, 1, 0, 1, 7'h07, 8'h00);
    settle();
    chk("spi_lock_grant", 32'(req_grant), 1);
    cyc();
    rq(REQ_SPI, 0, 0, 0, 7'h00, 8'h00);
    rq(REQ_IRQ, 1, 0, 0, 7'h05, 8'h00);
    settle();
    chk("spi_lock_ignored", 32'(req_grant), 4);
    cyc();
    rq(REQ_IRQ, 0, 0, 0, 7'h00, 8'h00);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
